timer_countdown: RTL and testbench
==================================

Name: timer_countdown

Overview:
- Consumer end of the keypad digit interface. Takes the three BCD digits produced by the switch-entry block (units_of_seconds, tens_of_seconds, units_of_minutes) and counts them down to 0:00 at one step per second.
- Drives the remaining-time digits to the display path and the heater-enable to the magnetron control.
- Handles start, pause, door-open interlock, clear and completion.

Parameters:
- TICK_DIV, 50000000: clk cycles per one-second decrement. Minimum 2. The bench uses 4.
- CNT_W, 26: prescaler width. Must satisfy 2^CNT_W >= TICK_DIV.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- in_units_of_seconds  input  4  entered seconds units digit (BCD)
- in_tens_of_seconds  input  4  entered seconds tens digit (BCD)
- in_units_of_minutes  input  4  entered minutes digit (BCD)
- start  input  1  level, sampled each cycle
- pause  input  1  level, sampled each cycle
- clear  input  1  level, sampled each cycle
- door_open  input  1  interlock, level
- units_of_seconds  output  4  remaining seconds units (registered)
- tens_of_seconds  output  4  remaining seconds tens (registered)
- units_of_minutes  output  4  remaining minutes (registered)
- running  output  1  high in RUN
- heater_on  output  1  running & ~door_open
- done  output  1  one-cycle pulse on reaching 0:00
- alarm  output  1  high in DONE

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, prescaler=0, all digit outputs 0, running=0, done=0, alarm=0.
- Input clamp: seconds-units and minutes digits >9 become 9. Seconds-tens digit >5 becomes 5.
- Priority when inputs coincide: clear > door_open > pause > start.
- IDLE state:
  - Digit registers load the clamped inputs every cycle (1-cycle latency).
  - start=1 & door_open=0 & clamped value != 0:00 -> RUN. Same edge: digits take the clamped inputs and prescaler=0.
  - start with 0:00 or with door_open=1 is ignored.
- RUN state:
  - Prescaler increments each cycle. At TICK_DIV-1 it wraps to 0 and a tick occurs.
  - Tick decrement:
    - If units_of_seconds != 0, decrement it.
    - Otherwise units_of_seconds=9. Then if tens_of_seconds != 0, decrement it.
    - Otherwise tens_of_seconds=5 and units_of_minutes decrements.
  - Tick while value is 0:01 -> digits become 0:00, state goes to DONE, done=1 for exactly that one cycle.
  - pause=1 or door_open=1 -> PAUSED. Prescaler is held, not cleared, and no tick occurs that cycle.
  - clear=1 -> IDLE.
- PAUSED state:
  - Digits and prescaler hold.
  - start=1 & door_open=0 -> RUN, prescaler continues from its held value.
  - clear=1 -> IDLE.
- DONE state:
  - Digits hold 0:00 and alarm=1.
  - start or clear -> IDLE. Digits reload from the inputs on the next cycle.
- Outputs:
  - running is 1 only in RUN.
  - heater_on is combinational: running & ~door_open.
  - Because door_open moves RUN to PAUSED on the next edge, heater_on drops in the same cycle that door_open rises.
- Maximum value 9:59. The decrement never underflows because the 0:00 check precedes borrow.
- rst in any state, including mid-tick, returns to the reset values on that edge.

Test Plan (TICK_DIV=4):
- Reset with digits 3:45 applied -> cycle after rst release the outputs read 3:45, state IDLE, running=0.
- Load 0:12, start 1 cycle -> running=1, 0:11 after 4 cycles, 0:10 after 8, 0:09 after 12 (borrow). done pulses once at cycle 48 with 0:00, alarm stays 1, running=0.
- Load 1:00, start -> after 4 cycles outputs 0:59 (double borrow). Inputs 1:7:F (tens=7, units=F) clamp to 1:59.
- Run 0:05, raise door_open mid-second -> heater_on=0 that cycle, state PAUSED. Then start with door_open=1 is ignored. Then door closed + start resumes and the next decrement lands at the remaining prescaler count, not a full 4.
- Start with 0:00 -> stays IDLE, no done pulse. clear and start asserted together in RUN -> IDLE.
- Assert rst during RUN at 0:03 -> all outputs 0 next cycle, no done pulse.

Source files
------------

// File: rtl/timer_countdown.sv
// timer_countdown
//   Counts an entered M:SS value down to 0:00, one step per second, and drives the
//   remaining-time digits plus the heater enable. Handles start, pause, the
//   door-open interlock, clear and completion.
//
// Parameters
//   TICK_DIV  clk cycles per one-second decrement (>= 2)
//   CNT_W     prescaler width, 2**CNT_W >= TICK_DIV
//
// Ports
//   clk, rst                system clock, synchronous active-high reset
//   in_units_of_seconds     entered seconds units digit (BCD, clamped to 9)
//   in_tens_of_seconds      entered seconds tens digit (BCD, clamped to 5)
//   in_units_of_minutes     entered minutes digit (BCD, clamped to 9)
//   start, pause, clear     level controls, priority clear > door_open > pause > start
//   door_open               interlock level
//   units_of_seconds,
//   tens_of_seconds,
//   units_of_minutes        remaining time (registered)
//   running                 high while counting
//   heater_on               running & ~door_open (combinational)
//   done                    one-cycle pulse on reaching 0:00
//   alarm                   high while sitting at 0:00 after completion
module timer_countdown #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned CNT_W    = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in_units_of_seconds,
  input  logic [3:0] in_tens_of_seconds,
  input  logic [3:0] in_units_of_minutes,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic       door_open,
  output logic [3:0] units_of_seconds,
  output logic [3:0] tens_of_seconds,
  output logic [3:0] units_of_minutes,
  output logic       running,
  output logic       heater_on,
  output logic       done,
  output logic       alarm
);

  typedef enum logic [1:0] {StIdle, StRun, StPaused, StDone} state_e;

  localparam logic [CNT_W-1:0] TickLast = CNT_W'(TICK_DIV - 1);

  state_e           state_q;
  logic [CNT_W-1:0] presc_q;
  logic [3:0]       su_q, st_q, um_q;
  logic             running_q, done_q, alarm_q;

  // Clamped entry digits
  logic [3:0] set_su, set_st, set_um;
  logic       set_zero;

  always_comb begin
    set_su   = (in_units_of_seconds > 4'd9) ? 4'd9 : in_units_of_seconds;
    set_st   = (in_tens_of_seconds  > 4'd5) ? 4'd5 : in_tens_of_seconds;
    set_um   = (in_units_of_minutes > 4'd9) ? 4'd9 : in_units_of_minutes;
    set_zero = (set_su == 4'd0) && (set_st == 4'd0) && (set_um == 4'd0);
  end

  // One-second decrement with BCD borrow across the three digits
  logic [3:0] dec_su, dec_st, dec_um;
  logic       last_sec;

  always_comb begin
    dec_su = su_q - 4'd1;
    dec_st = st_q;
    dec_um = um_q;
    if (su_q == 4'd0) begin
      dec_su = 4'd9;
      if (st_q != 4'd0) begin
        dec_st = st_q - 4'd1;
      end else begin
        dec_st = 4'd5;
        dec_um = um_q - 4'd1;
      end
    end
    last_sec = (su_q == 4'd1) && (st_q == 4'd0) && (um_q == 4'd0);
  end

  // Start is honoured only when nothing of higher priority is asserted
  logic go;
  assign go = start && !clear && !door_open && !pause;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      presc_q   <= '0;
      su_q      <= 4'd0;
      st_q      <= 4'd0;
      um_q      <= 4'd0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          su_q <= set_su;
          st_q <= set_st;
          um_q <= set_um;
          if (go && !set_zero) begin
            state_q   <= StRun;
            presc_q   <= '0;
            running_q <= 1'b1;
          end
        end
        StRun: begin
          if (clear) begin
            state_q   <= StIdle;
            running_q <= 1'b0;
          end else if (door_open || pause) begin
            // Prescaler keeps its phase so a resume finishes the partial second
            state_q   <= StPaused;
            running_q <= 1'b0;
          end else if (presc_q == TickLast) begin
            presc_q <= '0;
            su_q    <= dec_su;
            st_q    <= dec_st;
            um_q    <= dec_um;
            if (last_sec) begin
              state_q   <= StDone;
              running_q <= 1'b0;
              done_q    <= 1'b1;
              alarm_q   <= 1'b1;
            end
          end else begin
            presc_q <= presc_q + 1'b1;
          end
        end
        StPaused: begin
          if (clear) begin
            state_q <= StIdle;
          end else if (go) begin
            state_q   <= StRun;
            running_q <= 1'b1;
          end
        end
        StDone: begin
          if (clear || start) begin
            state_q <= StIdle;
            alarm_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          running_q <= 1'b0;
          alarm_q   <= 1'b0;
        end
      endcase
    end
  end

  assign units_of_seconds = su_q;
  assign tens_of_seconds  = st_q;
  assign units_of_minutes = um_q;
  assign running          = running_q;
  assign heater_on        = running_q & ~door_open;
  assign done             = done_q;
  assign alarm            = alarm_q;

endmodule

// File: tb/tb_timer_countdown.sv
// Directed bench for timer_countdown with TICK_DIV=4. A seconds-based model
// tracks the remaining time and phase; every negedge the DUT is compared to it,
// and hand-computed literals pin the model at key points.
module tb_timer_countdown;

  localparam int unsigned TickDiv = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_su, in_st, in_um;
  logic       start, pause, clear, door_open;
  logic [3:0] su, st, um;
  logic       running, heater_on, done, alarm;

  timer_countdown #(
    .TICK_DIV(TickDiv),
    .CNT_W   (3)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .in_units_of_seconds(in_su),
    .in_tens_of_seconds (in_st),
    .in_units_of_minutes(in_um),
    .start              (start),
    .pause              (pause),
    .clear              (clear),
    .door_open          (door_open),
    .units_of_seconds   (su),
    .tens_of_seconds    (st),
    .units_of_minutes   (um),
    .running            (running),
    .heater_on          (heater_on),
    .done               (done),
    .alarm              (alarm)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input int actual, input int expected);
    n_vec++;
    if (actual != expected) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // Model: remaining time as plain seconds, elapsed cycles within the second
  localparam int MIdle = 0, MRun = 1, MPaused = 2, MDone = 3;
  int m_mode = MIdle;
  int m_rem  = 0;
  int m_frac = 0;
  bit m_done = 1'b0;

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  always @(posedge clk) begin
    int entered;
    bit go;
    entered = min_i(int'(in_um), 9) * 60 + min_i(int'(in_st), 5) * 10 + min_i(int'(in_su), 9);
    go = start && !clear && !door_open && !pause;
    m_done = 1'b0;
    if (rst) begin
      m_mode = MIdle;
      m_rem  = 0;
      m_frac = 0;
    end else begin
      case (m_mode)
        MIdle: begin
          m_rem = entered;
          if (go && entered != 0) begin
            m_mode = MRun;
            m_frac = 0;
          end
        end
        MRun: begin
          if (clear) m_mode = MIdle;
          else if (door_open || pause) m_mode = MPaused;
          else begin
            m_frac++;
            if (m_frac == TickDiv) begin
              m_frac = 0;
              m_rem--;
              if (m_rem == 0) begin
                m_mode = MDone;
                m_done = 1'b1;
              end
            end
          end
        end
        MPaused: begin
          if (clear) m_mode = MIdle;
          else if (go) m_mode = MRun;
        end
        default: begin
          if (clear || start) m_mode = MIdle;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("units_of_seconds", int'(su), m_rem % 10);
      check("tens_of_seconds", int'(st), (m_rem % 60) / 10);
      check("units_of_minutes", int'(um), m_rem / 60);
      check("running", int'(running), int'(m_mode == MRun));
      check("heater_on", int'(heater_on), int'(m_mode == MRun && !door_open));
      check("done", int'(done), int'(m_done));
      check("alarm", int'(alarm), int'(m_mode == MDone));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_in(input int m, input int t, input int u);
    in_um = 4'(m);
    in_st = 4'(t);
    in_su = 4'(u);
  endtask

  task automatic lit_time(input string name, input int m, input int t, input int u);
    @(negedge clk);
    check({name, ".um"}, int'(um), m);
    check({name, ".st"}, int'(st), t);
    check({name, ".su"}, int'(su), u);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; clear = 1'b0; door_open = 1'b0;
    set_in(3, 4, 5);
    step(2);
    checking = 1'b1;
    lit_time("reset", 0, 0, 0);
    rst = 1'b0;
    step(1);
    lit_time("idle_load", 3, 4, 5);
    check("idle_running", int'(running), 0);

    // 0:12 countdown to completion
    set_in(0, 1, 2);
    step(1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    @(negedge clk);
    check("run_running", int'(running), 1);
    step(4); lit_time("t4", 0, 1, 1);
    step(4); lit_time("t8", 0, 1, 0);
    step(4); lit_time("t12_borrow", 0, 0, 9);
    step(35);
    lit_time("t47", 0, 0, 1);
    check("t47_done", int'(done), 0);
    step(1);
    lit_time("t48", 0, 0, 0);
    check("t48_done", int'(done), 1);
    check("t48_alarm", int'(alarm), 1);
    check("t48_running", int'(running), 0);
    step(1);
    @(negedge clk);
    check("t49_done", int'(done), 0);
    check("t49_alarm", int'(alarm), 1);

    // 1:00 double borrow, leave DONE via start
    set_in(1, 0, 0);
    start = 1'b1;
    step(2);
    start = 1'b0;
    step(4);
    lit_time("double_borrow", 0, 5, 9);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    set_in(1, 7, 15);
    step(1);
    lit_time("clamp", 1, 5, 9);

    // 0:05 with door interlock mid-second
    set_in(0, 0, 5);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
    door_open = 1'b1;
    @(negedge clk);
    check("door_heater", int'(heater_on), 0);
    check("door_running_still", int'(running), 1);
    step(1);
    @(negedge clk);
    check("door_paused", int'(running), 0);
    start = 1'b1;
    step(2);
    @(negedge clk);
    check("door_start_ignored", int'(running), 0);
    door_open = 1'b0;
    step(1);
    start = 1'b0;
    step(1);
    lit_time("resume_partial_a", 0, 0, 5);
    step(1);
    lit_time("resume_partial_b", 0, 0, 4);

    // pause and resume, then clear+start together
    pause = 1'b1;
    step(1);
    pause = 1'b0;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
    clear = 1'b1;
    start = 1'b1;
    step(1);
    clear = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("clear_start_idle", int'(running), 0);

    // start with 0:00 is ignored
    set_in(0, 0, 0);
    step(1);
    start = 1'b1;
    step(2);
    start = 1'b0;
    @(negedge clk);
    check("zero_start_running", int'(running), 0);
    check("zero_start_done", int'(done), 0);

    // reset during RUN at 0:03
    set_in(0, 0, 3);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
    rst = 1'b1;
    step(1);
    lit_time("rst_run", 0, 0, 0);
    check("rst_running", int'(running), 0);
    check("rst_done", int'(done), 0);
    check("rst_alarm", int'(alarm), 0);
    rst = 1'b0;
    step(3);
    @(negedge clk);
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
